dct_mac_pipe: RTL and testbench

// - Parametrised, pipelined multiply-accumulate unit for the fdct_zigzag DCT datapath; successor to the fixed macu.
// - Registers each din*coef product (mult_res), sums N_TAPS products per vector and emits one scaled, saturated result.
// - Adds framing, tap counting, a sticky protocol-error flag and optional rounding.
// - Instantiated once per dct_unit inside each dct_block.

---
 rtl/dct_mac_pipe.sv | 141 ++++++++++++++
 tb/tb_dct_mac_pipe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_mac_pipe.sv
// Pipelined signed multiply-accumulate for the DCT datapath: one product per cycle,
// N_TAPS products per framed vector, scaled and saturated result. Define DCT_MAC_ROUND_EN for round-half-up scaling.
module dct_mac_pipe #(
  parameter int DIN_W  = 8,
  parameter int COEF_W = 16,
  parameter int N_TAPS = 8,
  parameter int OUT_W  = 12,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic signed [DIN_W-1:0]  din,
  input  logic signed [COEF_W-1:0] coef,
  input  logic                     err_clr,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     busy,
  output logic                     err
);

  localparam int PROD_W = DIN_W + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(N_TAPS) + 1;
  localparam int CNT_W  = $clog2(N_TAPS + 2);
  // One guard bit above the accumulator so the rounding bias can never wrap.
  localparam int SCL_W  = ACC_W + 1;

  localparam logic signed [SCL_W-1:0] OUT_MAX = SCL_W'((64'(1) << (OUT_W - 1)) - 64'(1));
  localparam logic signed [SCL_W-1:0] OUT_MIN = ~OUT_MAX;
  localparam logic [CNT_W-1:0]        CNT_FULL = CNT_W'(N_TAPS);
  localparam logic [CNT_W-1:0]        CNT_OVER = CNT_W'(N_TAPS + 1);

  typedef enum logic [0:0] {IDLE, ACC} state_t;

  state_t                    state_reg, state_next;
  logic signed [PROD_W-1:0]  mult_res_reg;
  logic                      v1_reg, first1_reg, last1_reg;
  logic signed [ACC_W-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]          tap_cnt_reg, tap_cnt_next;
  logic signed [ACC_W-1:0]   prod_ext, acc_sum;
  logic [CNT_W-1:0]          cnt_inc;
  logic                      emit, err_set;
  logic signed [SCL_W-1:0]   acc_wide, scaled;
  logic signed [OUT_W-1:0]   sat_data;

  // Stage 1: register the full-width product with its framing bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mult_res_reg <= '0;
      v1_reg       <= 1'b0;
      first1_reg   <= 1'b0;
      last1_reg    <= 1'b0;
    end else if (ena) begin
      v1_reg <= in_valid;
      if (in_valid) begin
        mult_res_reg <= PROD_W'(din) * PROD_W'(coef);
        first1_reg   <= in_first;
        last1_reg    <= in_last;
      end
    end
  end

  assign prod_ext = ACC_W'(mult_res_reg);
  assign acc_sum  = acc_reg + prod_ext;
  assign cnt_inc  = (tap_cnt_reg >= CNT_OVER) ? tap_cnt_reg : tap_cnt_reg + CNT_W'(1);

  // Stage 2 framing FSM: a first tap always (re)starts a vector, even over an open one.
  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    tap_cnt_next = tap_cnt_reg;
    emit         = 1'b0;
    err_set      = 1'b0;
    if (v1_reg) begin
      if (first1_reg) begin
        err_set      = (state_reg == ACC);
        acc_next     = prod_ext;
        tap_cnt_next = CNT_W'(1);
        if (last1_reg) begin
          emit       = 1'b1;
          state_next = IDLE;
          if (N_TAPS != 1) err_set = 1'b1;
        end else begin
          state_next = ACC;
        end
      end else if (state_reg == IDLE) begin
        err_set = 1'b1;
      end else begin
        acc_next     = acc_sum;
        tap_cnt_next = cnt_inc;
        if (last1_reg) begin
          emit       = 1'b1;
          state_next = IDLE;
          if (cnt_inc != CNT_FULL) err_set = 1'b1;
        end else if (cnt_inc > CNT_FULL) begin
          err_set = 1'b1;
        end
      end
    end
  end

  assign acc_wide = SCL_W'(acc_next);

`ifdef DCT_MAC_ROUND_EN
  localparam logic signed [SCL_W-1:0] RND_BIAS = SCL_W'((64'(1) << SHIFT) >> 1);
  assign scaled = (acc_wide + RND_BIAS) >>> SHIFT;
`else
  assign scaled = acc_wide >>> SHIFT;
`endif

  always_comb begin
    sat_data = scaled[OUT_W-1:0];
    if (scaled > OUT_MAX)      sat_data = OUT_MAX[OUT_W-1:0];
    else if (scaled < OUT_MIN) sat_data = OUT_MIN[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      tap_cnt_reg <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      err         <= 1'b0;
    end else if (ena) begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      tap_cnt_reg <= tap_cnt_next;
      out_valid   <= emit;
      if (emit) out_data <= sat_data;
      if (err_clr)      err <= 1'b0;
      else if (err_set) err <= 1'b1;
    end
  end

  assign busy = (state_reg == ACC);

endmodule

// File: tb/tb_dct_mac_pipe.sv
// Directed bench for dct_mac_pipe: table of full vectors checked on a SHIFT=0 and a SHIFT=2
// instance, plus hand sequences for back-to-back, framing errors, stalls and mid-vector reset.
module tb_dct_mac_pipe;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               ena = 1'b1;
  logic               in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic signed [7:0]  din = '0;
  logic signed [15:0] coef = '0;
  logic               err_clr = 1'b0;
  logic               out_valid, busy, err;
  logic signed [11:0] out_data;
  logic               out_valid_r, busy_r, err_r;
  logic signed [11:0] out_data_r;

  dct_mac_pipe dut (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .din(din), .coef(coef), .err_clr(err_clr),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .err(err)
  );

  dct_mac_pipe #(.SHIFT(2)) dut_r (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .din(din), .coef(coef), .err_clr(err_clr),
    .out_valid(out_valid_r), .out_data(out_data_r), .busy(busy_r), .err(err_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0][7:0]  din;
    logic [7:0][15:0] coef;
    int               exp;
    int               exp_r;
  } vec_t;

  typedef struct {
    int cyc;
    int data;
  } ev_t;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  q[$];
  ev_t  qr[$];
  vec_t tbl[11];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && ena && out_valid)   q.push_back('{cyc, int'(out_data)});
    if (rst && ena && out_valid_r) qr.push_back('{cyc, int'(out_data_r)});
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic vec_t mk(input int d, input int c, input int e, input int er);
    vec_t v;
    for (int i = 0; i < 8; i++) begin
      v.din[i]  = 8'(d);
      v.coef[i] = 16'(c);
    end
    v.exp   = e;
    v.exp_r = er;
    return v;
  endfunction

  task automatic tap(input logic [7:0] d, input logic [15:0] c, input bit f, input bit l);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    din      = d;
    coef     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one 8-tap vector; stall_at>=0 holds ena low for 3 cycles before that tap.
  task automatic run_vec(input vec_t v, input int stall_at, output int last_cyc);
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        in_valid = 1'b1; in_first = (i == 0); in_last = (i == 7);
        din = v.din[i]; coef = v.coef[i];
        ena = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        ena = 1'b1;
      end
      tap(v.din[i], v.coef[i], i == 0, i == 7);
      if (i == 2) chk("busy_mid_vector", int'(busy), 1);
    end
    last_cyc = cyc;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("err_after_clr", int'(err), 0);
  endtask

  initial begin
    int lc, lc2;

    tbl[0] = mk(0, 2, 72, 18);
    for (int i = 0; i < 8; i++) tbl[0].din[i] = 8'(i + 1);
    tbl[1] = mk(1, 3, 24, 6);
    tbl[2] = mk(-1, 5, -40, -10);
    tbl[3] = mk(127, 32767, 2047, 2047);
    tbl[4] = mk(-128, 32767, -2048, -2048);
`ifdef DCT_MAC_ROUND_EN
    tbl[5] = mk(0, 0, 2047, 512);
    tbl[7] = mk(0, 0, -2048, -512);
    tbl[8] = mk(0, 0, 6, 2);
    tbl[9] = mk(0, 0, -6, -1);
`else
    tbl[5] = mk(0, 0, 2047, 511);
    tbl[7] = mk(0, 0, -2048, -513);
    tbl[8] = mk(0, 0, 6, 1);
    tbl[9] = mk(0, 0, -6, -2);
`endif
    tbl[5].din[0] = 8'd1;  tbl[5].coef[0] = 16'd2047;
    tbl[6] = mk(0, 0, 2047, 512);
    tbl[6].din[0] = 8'd1;  tbl[6].coef[0] = 16'd2047;
    tbl[6].din[3] = 8'd1;  tbl[6].coef[3] = 16'd1;
    tbl[7].din[0] = 8'hFF; tbl[7].coef[0] = 16'd2047;
    tbl[7].din[6] = 8'hFF; tbl[7].coef[6] = 16'd2;
    tbl[8].din[0] = 8'd6;  tbl[8].coef[0] = 16'd1;
    tbl[9].din[0] = 8'(-6); tbl[9].coef[0] = 16'd1;
    tbl[10] = mk(0, 0, -400, -100);
    for (int i = 0; i < 8; i++) begin
      tbl[10].din[i]  = 8'(i + 1);
      tbl[10].coef[i] = (i % 2 == 0) ? 16'd100 : 16'(-100);
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_err", int'(err), 0);
    rst = 1'b1;
    idle(2);

    // Table of complete, well-framed vectors
    for (int r = 0; r < 11; r++) begin
      q.delete();
      qr.delete();
      run_vec(tbl[r], -1, lc);
      idle(3);
      chk($sformatf("row%0d_count", r), q.size(), 1);
      if (q.size() >= 1) begin
        chk($sformatf("row%0d_latency", r), q[0].cyc, lc + 1);
        chk($sformatf("row%0d_data", r), q[0].data, tbl[r].exp);
      end
      chk($sformatf("row%0d_count_shift2", r), qr.size(), 1);
      if (qr.size() >= 1) chk($sformatf("row%0d_data_shift2", r), qr[0].data, tbl[r].exp_r);
      chk($sformatf("row%0d_err", r), int'(err), 0);
      chk($sformatf("row%0d_busy_end", r), int'(busy), 0);
    end

    // Back-to-back vectors, no bubble
    q.delete();
    run_vec(tbl[1], -1, lc);
    run_vec(tbl[2], -1, lc2);
    idle(3);
    chk("b2b_count", q.size(), 2);
    if (q.size() >= 2) begin
      chk("b2b_cyc0", q[0].cyc, lc + 1);
      chk("b2b_data0", q[0].data, 24);
      chk("b2b_cyc1", q[1].cyc, lc2 + 1);
      chk("b2b_data1", q[1].data, -40);
    end
    chk("b2b_err", int'(err), 0);

    // Sample without first while idle: discarded, err set
    q.delete();
    tap(8'd5, 16'd3, 1'b0, 1'b0);
    idle(3);
    chk("nofirst_count", q.size(), 0);
    chk("nofirst_err", int'(err), 1);
    chk("nofirst_busy", int'(busy), 0);
    clear_err();

    // err_clr wins over a simultaneous error
    tap(8'd5, 16'd3, 1'b0, 1'b0);
    in_valid = 1'b0;
    err_clr  = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("clr_priority_err", int'(err), 0);
    idle(2);
    chk("clr_priority_err_hold", int'(err), 0);

    // Short vector: last on tap 5 still emits, flags err
    q.delete();
    for (int i = 0; i < 6; i++) tap(8'd1, 16'd1, i == 0, i == 5);
    lc = cyc;
    idle(3);
    chk("short_count", q.size(), 1);
    if (q.size() >= 1) begin
      chk("short_latency", q[0].cyc, lc + 1);
      chk("short_data", q[0].data, 6);
    end
    chk("short_err", int'(err), 1);
    chk("short_busy", int'(busy), 0);
    clear_err();

    // First inside an open vector: abort, restart from that sample
    q.delete();
    for (int i = 0; i < 3; i++) tap(8'd9, 16'd9, i == 0, 1'b0);
    for (int i = 0; i < 8; i++) tap(8'd1, 16'd1, i == 0, i == 7);
    idle(3);
    chk("abort_count", q.size(), 1);
    if (q.size() >= 1) chk("abort_data", q[0].data, 8);
    chk("abort_err", int'(err), 1);
    clear_err();

    // Stall mid-vector and again with the last tap in flight
    q.delete();
    run_vec(tbl[0], 4, lc);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    ena = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("stall_no_early_out", int'(out_valid), 0);
    ena = 1'b1;
    idle(4);
    chk("stall_count", q.size(), 1);
    if (q.size() >= 1) begin
      chk("stall_latency", q[0].cyc, lc + 4);
      chk("stall_data", q[0].data, 72);
    end
    chk("stall_err", int'(err), 0);

    // Reset in the middle of a vector
    q.delete();
    for (int i = 0; i < 4; i++) tap(tbl[0].din[i], tbl[0].coef[i], i == 0, 1'b0);
    in_valid = 1'b0; in_first = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_data", int'(out_data), 0);
    chk("midrst_err", int'(err), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(3);
    chk("midrst_count", q.size(), 0);
    chk("midrst_busy_after", int'(busy), 0);
    run_vec(tbl[0], -1, lc);
    idle(3);
    chk("postrst_count", q.size(), 1);
    if (q.size() >= 1) chk("postrst_data", q[0].data, 72);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
